// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with prescaler, load, wrap/one-shot and terminal count.
//   clk, reset (sync, active-high); en gates the prescaler; load/load_val synchronous load (clamped to MAX);
//   dir 1=up 0=down; one_shot 1=halt at boundary; cnt count; tc one-cycle boundary pulse; done sticky halt flag.
module prog_counter #(
   parameter int WIDTH    = 8,
   parameter int MAX      = 2**WIDTH-1,
   parameter int PRESCALE = 1,
   parameter int INIT     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             one_shot,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             done
);
   typedef enum logic {RUN, HALT} state_t;
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE-1);
   state_t state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic tc_q, tc_d, done_q, done_d;
   logic tick, at_end;
   assign tick = en && pre_q == PRE_LAST;
   assign at_end = dir ? cnt_q == MAX_V : cnt_q == '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= INIT_V;
         pre_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      done_d  = done_q;
      tc_d    = 1'b0;
      if (load) begin
         cnt_d   = load_val > MAX_V ? MAX_V : load_val;
         pre_d   = '0;
         done_d  = 1'b0;
         state_d = RUN;
      end else if (state_q == RUN && en) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick && !at_end) begin
            cnt_d = dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
         end else if (tick) begin
            tc_d = 1'b1;
            // one-shot holds the boundary value; wrap jumps to the opposite end
            cnt_d = one_shot ? cnt_q : (dir ? '0 : MAX_V);
            if (one_shot) begin
               done_d  = 1'b1;
               state_d = HALT;
            end
         end
      end
   end
   assign cnt  = cnt_q;
   assign tc   = tc_q;
   assign done = done_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: randomized and directed check of two prog_counter configurations against a behavioural model.
module tb_prog_counter;
   localparam int A_MAX = 9,  A_PS = 1, A_INIT = 5;
   localparam int B_MAX = 12, B_PS = 4, B_INIT = 0;
   logic clk = 1'b0;
   logic reset = 1'b1, en = 1'b0, load = 1'b0, dir = 1'b1, one_shot = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] cnt_a, cnt_b;
   logic tc_a, tc_b, done_a, done_b;
   int n_chk = 0, n_err = 0;
   int p_max[2] = '{A_MAX, B_MAX};
   int p_ps[2] = '{A_PS, B_PS};
   int p_init[2] = '{A_INIT, B_INIT};
   int m_cnt[2], m_pre[2], m_tc[2], m_done[2], m_halt[2];
   always #5 clk = ~clk;
   prog_counter #(.WIDTH(4), .MAX(A_MAX), .PRESCALE(A_PS), .INIT(A_INIT)) dut_a (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .dir(dir),
      .one_shot(one_shot), .cnt(cnt_a), .tc(tc_a), .done(done_a));
   prog_counter #(.WIDTH(4), .MAX(B_MAX), .PRESCALE(B_PS), .INIT(B_INIT)) dut_b (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .dir(dir),
      .one_shot(one_shot), .cnt(cnt_b), .tc(tc_b), .done(done_b));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask
   task automatic mstep(input int k);
      m_tc[k] = 0;
      if (reset) begin
         m_cnt[k] = p_init[k]; m_pre[k] = 0; m_done[k] = 0; m_halt[k] = 0;
      end else if (load) begin
         m_cnt[k] = int'(load_val) > p_max[k] ? p_max[k] : int'(load_val);
         m_pre[k] = 0; m_done[k] = 0; m_halt[k] = 0;
      end else if (!m_halt[k] && en) begin
         m_pre[k]++;
         if (m_pre[k] == p_ps[k]) begin
            m_pre[k] = 0;
            if (dir ? m_cnt[k] == p_max[k] : m_cnt[k] == 0) begin
               m_tc[k] = 1;
               if (one_shot) begin m_done[k] = 1; m_halt[k] = 1; end
               else m_cnt[k] = dir ? 0 : p_max[k];
            end else m_cnt[k] += dir ? 1 : -1;
         end
      end
   endtask
   task automatic cyc(input logic r, input logic e, input logic l, input int lv, input logic d, input logic os);
      reset = r; en = e; load = l; load_val = 4'(lv); dir = d; one_shot = os;
      @(posedge clk);
      mstep(0);
      mstep(1);
      #1;
      check("a.cnt", 32'(cnt_a), 32'(m_cnt[0]));
      check("a.tc", 32'(tc_a), 32'(m_tc[0]));
      check("a.done", 32'(done_a), 32'(m_done[0]));
      check("b.cnt", 32'(cnt_b), 32'(m_cnt[1]));
      check("b.tc", 32'(tc_b), 32'(m_tc[1]));
      check("b.done", 32'(done_b), 32'(m_done[1]));
   endtask
   initial begin
      logic d, os;
      cyc(1, 1, 1, 3, 1, 1);
      cyc(1, 0, 0, 0, 1, 0);
      check("a.reset_cnt", 32'(cnt_a), 32'(A_INIT));
      for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 1, 1, 3, 0, 0);
      for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 7, 1, 1);
      for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 1, 1);
      check("a.halt_cnt", 32'(cnt_a), 32'(A_MAX));
      check("b.halt_done", 32'(done_b), 32'd1);
      cyc(0, 1, 1, 2, 1, 1);
      check("a.reload_done", 32'(done_a), 32'd0);
      cyc(0, 1, 1, 15, 1, 0);
      check("a.clamp", 32'(cnt_a), 32'(A_MAX));
      check("b.clamp", 32'(cnt_b), 32'(B_MAX));
      cyc(0, 1, 1, 4, 1, 0);
      check("a.load_on_tick_tc", 32'(tc_a), 32'd0);
      for (int i = 0; i < 6; i++)
         foreach (p_ps[j]) cyc(0, i % 3 != 2 && j != 2, 0, 0, 1, 0);
      for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 1);
      cyc(1, 1, 0, 0, 0, 1);
      check("a.reset_halt", 32'(cnt_a), 32'(A_INIT));
      check("a.reset_done", 32'(done_a), 32'd0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 1, 0);
      d = 1'b1;
      os = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) d = ~d;
         if ($urandom_range(0, 19) == 0) os = ~os;
         cyc($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 4,
             int'($urandom_range(0, 15)), d, os);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
